// File: rtl/pc_gen_unit.sv
// PC register and next-PC selection with trap/mret redirect, EPC, circular return-address stack and mispredict counter.
// Optional misaligned-redirect check is enabled by defining PC_ALIGN_CHK_EN.
module pc_gen_unit #(
    parameter int               DATAW     = 32,
    parameter logic [DATAW-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             b_type_jump_flag,
    input  logic             jal_instr,
    input  logic             jalr_instr,
    input  logic             is_call,
    input  logic             is_ret,
    input  logic [DATAW-1:0] alu_res,
    input  logic [DATAW-1:0] pc_add_imme,
    input  logic             trap_req,
    input  logic [DATAW-1:0] trap_vec,
    input  logic             mret_req,
    output logic [DATAW-1:0] pc,
    output logic [DATAW-1:0] pc_add_4,
    output logic [DATAW-1:0] epc,
    output logic [DATAW-1:0] ras_top,
    output logic             ras_valid,
    output logic [CNT_W-1:0] ras_mispred_cnt,
    output logic             misalign_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [DATAW-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W:0]   ras_cnt;

    logic [DATAW-1:0] jalr_target;
    logic [DATAW-1:0] redirect_target;
    logic [DATAW-1:0] next_pc;
    logic             jump;
    logic             redirect;
    logic             misaligned;
    logic             active;
    logic             ras_en;
    logic             push;
    logic             pop;
    logic             mispred;

    assign pc_add_4  = pc + DATAW'(4);
    assign top_idx   = ras_ptr - 1'b1;
    assign ras_top   = ras_mem[top_idx];
    assign ras_valid = (ras_cnt != '0);

    // Target selection; a cycle is "active" when neither stall, trap nor mret claims it.
    always_comb begin
        jalr_target     = alu_res & ~DATAW'(1);
        jump            = b_type_jump_flag | jal_instr;
        redirect        = jump | jalr_instr;
        redirect_target = jump ? pc_add_imme : jalr_target;
`ifdef PC_ALIGN_CHK_EN
        misaligned      = redirect && (redirect_target[1:0] != 2'b00);
`else
        misaligned      = 1'b0;
`endif
        active          = !stall && !trap_req && !mret_req;
        ras_en          = active && !misaligned;
        push            = ras_en && (jal_instr || jalr_instr) && is_call;
        pop             = ras_en && jalr_instr && is_ret;
        mispred         = pop && ras_valid && (ras_top != jalr_target);

        if (trap_req)
            next_pc = trap_vec;
        else if (stall)
            next_pc = pc;
        else if (mret_req)
            next_pc = epc;
        else if (misaligned)
            next_pc = pc;
        else if (redirect)
            next_pc = redirect_target;
        else
            next_pc = pc_add_4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= RESET_PC;
            epc <= '0;
        end else begin
            pc <= next_pc;
            if (trap_req)
                epc <= pc;
        end
    end

    // A pop on an empty stack is a no-op, so push+pop when empty degrades to a plain push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_mem[i] <= '0;
        end else if (push && pop && ras_valid) begin
            ras_mem[top_idx] <= pc_add_4;
        end else if (push) begin
            ras_mem[ras_ptr] <= pc_add_4;
            ras_ptr          <= ras_ptr + 1'b1;
            if (ras_cnt != (PTR_W+1)'(RAS_DEPTH))
                ras_cnt <= ras_cnt + 1'b1;
        end else if (pop && ras_valid) begin
            ras_ptr <= ras_ptr - 1'b1;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ras_mispred_cnt <= '0;
        else if (mispred && (ras_mispred_cnt != '1))
            ras_mispred_cnt <= ras_mispred_cnt + 1'b1;
    end

`ifdef PC_ALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_err <= 1'b0;
        else
            misalign_err <= active && misaligned;
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios plus randomized traffic against a queue-based reference model.
// Honours PC_ALIGN_CHK_EN the same way the design does.
module tb_pc_gen_unit;

    localparam int          DW    = 32;
    localparam int          CW    = 3;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0, b_type_jump_flag = 1'b0, jal_instr = 1'b0, jalr_instr = 1'b0;
    logic          is_call = 1'b0, is_ret = 1'b0, trap_req = 1'b0, mret_req = 1'b0;
    logic [DW-1:0] alu_res = '0, pc_add_imme = '0, trap_vec = '0;
    logic [DW-1:0] pc, pc_add_4, epc, ras_top;
    logic          ras_valid, misalign_err;
    logic [CW-1:0] ras_mispred_cnt;

    pc_gen_unit #(.DATAW(DW), .RESET_PC(RPC), .RAS_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .b_type_jump_flag(b_type_jump_flag),
        .jal_instr(jal_instr), .jalr_instr(jalr_instr), .is_call(is_call), .is_ret(is_ret),
        .alu_res(alu_res), .pc_add_imme(pc_add_imme), .trap_req(trap_req), .trap_vec(trap_vec),
        .mret_req(mret_req), .pc(pc), .pc_add_4(pc_add_4), .epc(epc), .ras_top(ras_top),
        .ras_valid(ras_valid), .ras_mispred_cnt(ras_mispred_cnt), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    logic [31:0] m_pc, m_epc;
    logic [31:0] m_ras[$];
    int          m_cnt;
    logic        m_err;
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_pc  = RPC;
        m_epc = 32'h0;
        m_ras.delete();
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // Reference model: stack is a queue capped at DEPTH entries, oldest dropped from the front.
    task automatic modelStep();
        logic [31:0] pa4, tgt, jt;
        logic        taken, mis, push, pop;
        pa4   = m_pc + 32'd4;
        jt    = {alu_res[31:1], 1'b0};
        taken = b_type_jump_flag | jal_instr | jalr_instr;
        tgt   = (b_type_jump_flag | jal_instr) ? pc_add_imme : jt;
        m_err = 1'b0;
        if (trap_req) begin
            m_epc = m_pc;
            m_pc  = trap_vec;
        end else if (stall) begin
        end else if (mret_req) begin
            m_pc = m_epc;
        end else begin
`ifdef PC_ALIGN_CHK_EN
            mis = taken && (tgt % 4 != 0);
`else
            mis = 1'b0;
`endif
            if (mis) begin
                m_err = 1'b1;
            end else begin
                push = (jal_instr | jalr_instr) & is_call;
                pop  = jalr_instr & is_ret;
                if (pop && m_ras.size() > 0 && m_ras[$] != jt && m_cnt < (1 << CW) - 1)
                    m_cnt++;
                if (push && pop && m_ras.size() > 0)
                    m_ras[$] = pa4;
                else if (push) begin
                    m_ras.push_back(pa4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end else if (pop && m_ras.size() > 0)
                    void'(m_ras.pop_back());
                m_pc = taken ? tgt : pa4;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("pc", pc, m_pc);
        checkOutput("pc_add_4", pc_add_4, m_pc + 32'd4);
        checkOutput("epc", epc, m_epc);
        checkOutput("ras_valid", {31'b0, ras_valid}, {31'b0, m_ras.size() > 0});
        if (m_ras.size() > 0)
            checkOutput("ras_top", ras_top, m_ras[$]);
        checkOutput("mispred_cnt", {29'b0, ras_mispred_cnt}, m_cnt);
        checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
    endtask

    // Called #1 after a rising edge; drives one cycle of inputs and checks the result.
    task automatic applyStimulus(input logic s, b, j, jr, c, r, input logic [31:0] alu, imm,
                                 input logic t, input logic [31:0] tv, input logic m);
        stall = s; b_type_jump_flag = b; jal_instr = j; jalr_instr = jr;
        is_call = c; is_ret = r; alu_res = alu; pc_add_imme = imm;
        trap_req = t; trap_vec = tv; mret_req = m;
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle();          applyStimulus(0,0,0,0,0,0,0,0,0,0,0);   endtask
    task automatic jump(input logic [31:0] a); applyStimulus(0,0,1,0,0,0,0,a,0,0,0); endtask
    task automatic call(input logic [31:0] a); applyStimulus(0,0,1,0,1,0,0,a,0,0,0); endtask
    task automatic ret(input logic [31:0] a);  applyStimulus(0,0,0,1,0,1,a,0,0,0,0); endtask

    task automatic doReset();
        stall = 0; b_type_jump_flag = 0; jal_instr = 0; jalr_instr = 0;
        is_call = 0; is_ret = 0; trap_req = 0; mret_req = 0;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_pc", pc, RPC);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] randTarget();
        logic [31:0] v;
        v = $urandom & 32'h0000_FFFC;
        if ($urandom_range(0, 7) == 0) v = v | $urandom_range(1, 3);
        return v;
    endfunction

    initial begin
        @(posedge clk);
        #1;
        doReset();

        idle(); checkOutput("tp_idle1", pc, 32'h104);
        idle(); checkOutput("tp_idle2", pc, 32'h108);
        idle(); checkOutput("tp_idle3", pc, 32'h10C);

        jump(32'h200);
        call(32'h400);
        checkOutput("tp_call_pc", pc, 32'h400);
        checkOutput("tp_call_top", ras_top, 32'h204);
        ret(32'h205);
        checkOutput("tp_ret_pc", pc, 32'h204);
        checkOutput("tp_ret_valid", {31'b0, ras_valid}, 32'h0);

        jump(32'h10);
        call(32'h20); call(32'h30); call(32'h40); call(32'h50); call(32'h60);
        ret(32'h54); checkOutput("tp_pop1", pc, 32'h54);
        ret(32'h44); checkOutput("tp_pop2", pc, 32'h44);
        ret(32'h34); checkOutput("tp_pop3", pc, 32'h34);
        ret(32'h24); checkOutput("tp_pop4", pc, 32'h24);
        ret(32'h90); checkOutput("tp_pop5", pc, 32'h90);
        checkOutput("tp_pop5_valid", {31'b0, ras_valid}, 32'h0);

        jump(32'h20);
        call(32'h200);
        ret(32'h80);
        checkOutput("tp_mis_pc", pc, 32'h80);
        checkOutput("tp_mis_cnt", {29'b0, ras_mispred_cnt}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            call(32'h200);
            ret(32'h80);
        end
        checkOutput("tp_mis_sat", {29'b0, ras_mispred_cnt}, 32'h7);

        jump(32'hFFFF_FFFC);
        checkOutput("tp_wrap_a4", pc_add_4, 32'h0);
        idle(); checkOutput("tp_wrap_pc", pc, 32'h0);

        jump(32'h300);
        applyStimulus(1,0,0,0,0,0,0,0,1,32'h800,0);
        checkOutput("tp_trap_pc", pc, 32'h800);
        checkOutput("tp_trap_epc", epc, 32'h300);
        applyStimulus(0,0,0,0,0,0,0,0,0,0,1);
        checkOutput("tp_mret_pc", pc, 32'h300);
        applyStimulus(1,1,0,0,0,0,0,32'h500,0,0,0);
        checkOutput("tp_stall_pc", pc, 32'h300);

        applyStimulus(0,1,0,0,0,0,0,32'h402,0,0,0);
`ifdef PC_ALIGN_CHK_EN
        checkOutput("tp_mal_pc", pc, 32'h300);
        checkOutput("tp_mal_err", {31'b0, misalign_err}, 32'h1);
        idle();
        checkOutput("tp_mal_clr", {31'b0, misalign_err}, 32'h0);
`else
        checkOutput("tp_mal_pc", pc, 32'h402);
        checkOutput("tp_mal_err", {31'b0, misalign_err}, 32'h0);
`endif

        for (int n = 0; n < 800; n++) begin
            logic s, b, j, jr, c, r, t, m;
            logic [31:0] alu, imm, tv;
            if (n == 400) doReset();
            s   = ($urandom_range(0, 7) == 0);
            t   = ($urandom_range(0, 31) == 0);
            m   = ($urandom_range(0, 15) == 0);
            b   = ($urandom_range(0, 7) == 0);
            j   = ($urandom_range(0, 7) == 0);
            jr  = ($urandom_range(0, 4) == 0);
            c   = ($urandom_range(0, 2) == 0);
            r   = ($urandom_range(0, 2) == 0);
            imm = randTarget();
            tv  = $urandom & 32'h0000_FFFC;
            if (m_ras.size() > 0 && $urandom_range(0, 1) == 1)
                alu = m_ras[$] | 32'($urandom_range(0, 1));
            else
                alu = randTarget() | 32'($urandom_range(0, 1));
            applyStimulus(s, b, j, jr, c, r, alu, imm, t, tv, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
